// File: rtl/riscv_pkg.sv
// Shared fetch-side types: state encoding, buffered fetch entry and the canonical NOP.
package riscv_pkg;

    localparam int unsigned PC_MAX_W  = 64;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [PC_MAX_W-1:0] pc;
        logic [31:0]         instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Generic synchronous FIFO with clear; DEPTH must be a power of two so pointers wrap naturally.
module fetch_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 96
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         clear_i,
    input  logic                         push_i,
    input  logic [WIDTH-1:0]             pushData_i,
    input  logic                         pop_i,
    output logic [WIDTH-1:0]             popData_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rdPtr_q, wrPtr_q;
    logic [CNT_W-1:0] count_q;
    logic             doPush, doPop;

    assign full_o    = (count_q == CNT_W'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign count_o   = count_q;
    assign popData_o = mem_q[rdPtr_q];
    assign doPop     = pop_i && !empty_o;
    assign doPush    = push_i && (!full_o || doPop);

    always_ff @(posedge clk) begin
        if (doPush) begin
            mem_q[wrPtr_q] <= pushData_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clear_i) begin
            rdPtr_q <= '0;
            wrPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (doPush) begin
                wrPtr_q <= wrPtr_q + 1'b1;
            end
            if (doPop) begin
                rdPtr_q <= rdPtr_q + 1'b1;
            end
            if (doPush && !doPop) begin
                count_q <= count_q + 1'b1;
            end else if (doPop && !doPush) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/ifetch.sv
// Instruction fetch stage: single-outstanding imem requests, buffered words, redirect with drain.
// Optional macro IFETCH_MISALIGN_TRAP_EN adds fetch_misaligned and halts fetch on a misaligned redirect.
module ifetch
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN       = 64,
    parameter logic [63:0] RESET_PC   = 64'h0000_0000_8000_0000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    output logic [XLEN-1:0] pc_out,
    output logic [31:0]     instr_out,
    output logic            valid_out
`ifdef IFETCH_MISALIGN_TRAP_EN
    ,
    output logic            fetch_misaligned
`endif
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

    fetch_state_e     state_q, state_d;
    logic [XLEN-1:0]  pc_q, pc_d, reqPc_q, reqPc_d;
    logic [XLEN-1:0]  pcOut_q, pcOut_d;
    logic [31:0]      instrOut_q, instrOut_d;
    logic             validOut_q, validOut_d;
    logic [XLEN-1:0]  redirPc;
    logic             fetchHalted, reqFire;
    logic             fifoPush, fifoPop, fifoFull, fifoEmpty;
    logic [CNT_W-1:0] fifoCount;
    fetch_entry_t     pushEntry, headEntry;

`ifdef IFETCH_MISALIGN_TRAP_EN
    logic misaligned_q, misaligned_d, redirMisaligned;
    assign redirPc          = redirect_pc;
    assign redirMisaligned  = (redirect_pc[1:0] != 2'b00);
    assign fetchHalted      = misaligned_q;
    assign fetch_misaligned = misaligned_q;
`else
    assign redirPc     = redirect_pc & ~XLEN'(3);
    assign fetchHalted = 1'b0;
`endif

    // A slot is reserved before issuing, so the single in-flight response always fits.
    assign imem_req_valid = !reset && (state_q == FETCH) && !fetchHalted
                            && (fifoCount < CNT_W'(FIFO_DEPTH));
    assign imem_req_addr  = pc_q;
    assign reqFire        = imem_req_valid && imem_req_ready;

    assign pc_out    = pcOut_q;
    assign instr_out = instrOut_q;
    assign valid_out = validOut_q;

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(fetch_entry_t))
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .clear_i    (redirect),
        .push_i     (fifoPush),
        .pushData_i (pushEntry),
        .pop_i      (fifoPop),
        .popData_o  (headEntry),
        .full_o     (fifoFull),
        .empty_o    (fifoEmpty),
        .count_o    (fifoCount)
    );

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        reqPc_d    = reqPc_q;
        pcOut_d    = pcOut_q;
        instrOut_d = instrOut_q;
        validOut_d = validOut_q;
        fifoPush   = 1'b0;
        fifoPop    = 1'b0;
        pushEntry  = '{pc: PC_MAX_W'(reqPc_q), instr: imem_rsp_data};
`ifdef IFETCH_MISALIGN_TRAP_EN
        misaligned_d = misaligned_q;
`endif
        if (redirect) begin
            pc_d       = redirPc;
            instrOut_d = NOP_INSTR;
            validOut_d = 1'b0;
            // Any request still in flight must be drained; a response landing now retires it.
            case (state_q)
                FETCH:   state_d = reqFire ? DRAIN : FETCH;
                WAIT:    state_d = imem_rsp_valid ? FETCH : DRAIN;
                DRAIN:   state_d = imem_rsp_valid ? FETCH : DRAIN;
                default: state_d = FETCH;
            endcase
`ifdef IFETCH_MISALIGN_TRAP_EN
            misaligned_d = redirMisaligned;
            if (redirMisaligned) begin
                pcOut_d = redirect_pc;
            end
`endif
        end else begin
            case (state_q)
                FETCH: begin
                    if (reqFire) begin
                        reqPc_d = pc_q;
                        pc_d    = pc_q + XLEN'(4);
                        state_d = WAIT;
                    end
                end
                WAIT: begin
                    if (imem_rsp_valid) begin
                        fifoPush = 1'b1;
                        state_d  = FETCH;
                    end
                end
                DRAIN: begin
                    if (imem_rsp_valid) begin
                        state_d = FETCH;
                    end
                end
                default: state_d = FETCH;
            endcase
            if (!stall) begin
                if (!fifoEmpty) begin
                    fifoPop    = 1'b1;
                    pcOut_d    = headEntry.pc[XLEN-1:0];
                    instrOut_d = headEntry.instr;
                    validOut_d = 1'b1;
                end else begin
                    instrOut_d = NOP_INSTR;
                    validOut_d = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= FETCH;
            pc_q       <= RESET_PC[XLEN-1:0];
            reqPc_q    <= '0;
            pcOut_q    <= '0;
            instrOut_q <= NOP_INSTR;
            validOut_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            reqPc_q    <= reqPc_d;
            pcOut_q    <= pcOut_d;
            instrOut_q <= instrOut_d;
            validOut_q <= validOut_d;
        end
    end

`ifdef IFETCH_MISALIGN_TRAP_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            misaligned_q <= 1'b0;
        end else begin
            misaligned_q <= misaligned_d;
        end
    end
`endif

`ifndef SYNTHESIS
    rspNotInFetch: assert property (@(posedge clk) disable iff (reset)
        !(imem_rsp_valid && (state_q == FETCH)));
    noPushWhenFull: assert property (@(posedge clk) disable iff (reset)
        !(fifoPush && fifoFull));
`endif

endmodule

// File: tb/tb_ifetch.sv
// Directed bench for ifetch: cycle table for streaming/stall, plus redirect, wrap and alignment sequences.
module tb_ifetch;
    import riscv_pkg::*;

    localparam logic [63:0] BASE = 64'h0000_0000_8000_0000;

    typedef struct {
        bit          stall;
        bit          expReqValid;
        logic [63:0] expAddr;
        bit          expValid;
        logic [63:0] expPc;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [63:0] redirect_pc = 64'd0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [63:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'd0;
    logic [63:0] pc_out;
    logic [31:0] instr_out;
    logic        valid_out;
`ifdef IFETCH_MISALIGN_TRAP_EN
    logic        fetch_misaligned;
`endif

    int checks = 0;
    int failures = 0;

    // Memory responder state
    bit          pend = 1'b0;
    int          dueCnt = 0;
    int          memLat = 1;
    logic [31:0] pendData = 32'd0;
    bit          useOverride = 1'b0;
    logic [31:0] overrideData = 32'd0;
    bit          acceptedNow = 1'b0;
    logic [63:0] acceptedAddr = 64'd0;
    bit          sawDeadbeef = 1'b0;

    vec_t vecs[16];

    ifetch dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .pc_out         (pc_out),
        .instr_out      (instr_out),
        .valid_out      (valid_out)
`ifdef IFETCH_MISALIGN_TRAP_EN
        ,
        .fetch_misaligned (fetch_misaligned)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] dataOf(input logic [63:0] a);
        return a[31:0] ^ 32'h1357_0000;
    endfunction

    function automatic vec_t mkVec(input bit s, input bit rv, input logic [63:0] a,
                                   input bit v, input logic [63:0] p);
        vec_t r;
        r.stall = s; r.expReqValid = rv; r.expAddr = a; r.expValid = v; r.expPc = p;
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input bit st, input bit rd, input logic [63:0] rpc);
        stall = st;
        redirect = rd;
        redirect_pc = rpc;
    endtask

    // Advance to the next sampling point and play the memory side for the coming edge.
    task automatic stepCycle();
        @(negedge clk);
        redirect = 1'b0;
        acceptedNow = 1'b0;
        imem_rsp_valid = 1'b0;
        if (pend) begin
            if (dueCnt == 0) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data = pendData;
                pend = 1'b0;
            end else begin
                dueCnt--;
            end
        end
        if (imem_req_valid && imem_req_ready) begin
            pend = 1'b1;
            dueCnt = memLat - 1;
            pendData = useOverride ? overrideData : dataOf(imem_req_addr);
            acceptedNow = 1'b1;
            acceptedAddr = imem_req_addr;
        end
        if (instr_out == 32'hDEADBEEF) sawDeadbeef = 1'b1;
    endtask

    task automatic waitValid(input string name, input logic [63:0] expPc);
        int n = 0;
        while (!valid_out && n < 20) begin
            stepCycle();
            n++;
        end
        if (!valid_out) begin
            checks++;
            failures++;
            $display("[TB] FAIL %s_timeout: got no valid_out expected valid pc %h", name, expPc);
        end else begin
            checkOutput({name, "_pc"}, pc_out, expPc);
            checkOutput({name, "_instr"}, 64'(instr_out), 64'(dataOf(expPc)));
        end
    endtask

    initial begin
        logic [63:0] reqQ[$];
        logic [63:0] pcQ[$];
        int n;

        vecs[0]  = mkVec(1'b0, 1'b1, BASE,          1'b0, 64'd0);
        vecs[1]  = mkVec(1'b0, 1'b0, 64'd0,         1'b0, 64'd0);
        vecs[2]  = mkVec(1'b0, 1'b1, BASE + 64'd4,  1'b0, 64'd0);
        vecs[3]  = mkVec(1'b0, 1'b0, 64'd0,         1'b1, BASE);
        vecs[4]  = mkVec(1'b0, 1'b1, BASE + 64'd8,  1'b0, BASE);
        vecs[5]  = mkVec(1'b0, 1'b0, 64'd0,         1'b1, BASE + 64'd4);
        vecs[6]  = mkVec(1'b1, 1'b1, BASE + 64'd12, 1'b0, BASE + 64'd4);
        vecs[7]  = mkVec(1'b1, 1'b0, 64'd0,         1'b0, BASE + 64'd4);
        vecs[8]  = mkVec(1'b1, 1'b0, 64'd0,         1'b0, BASE + 64'd4);
        vecs[9]  = mkVec(1'b1, 1'b0, 64'd0,         1'b0, BASE + 64'd4);
        vecs[10] = mkVec(1'b0, 1'b0, 64'd0,         1'b0, BASE + 64'd4);
        vecs[11] = mkVec(1'b0, 1'b1, BASE + 64'd16, 1'b1, BASE + 64'd8);
        vecs[12] = mkVec(1'b0, 1'b0, 64'd0,         1'b1, BASE + 64'd12);
        vecs[13] = mkVec(1'b0, 1'b1, BASE + 64'd20, 1'b0, BASE + 64'd12);
        vecs[14] = mkVec(1'b0, 1'b0, 64'd0,         1'b1, BASE + 64'd16);
        vecs[15] = mkVec(1'b0, 1'b1, BASE + 64'd24, 1'b0, BASE + 64'd16);

        // Reset state
        repeat (3) @(negedge clk);
        checkOutput("reset_req_valid", 64'(imem_req_valid), 64'd0);
        checkOutput("reset_valid_out", 64'(valid_out), 64'd0);
        checkOutput("reset_pc_out", pc_out, 64'd0);
        checkOutput("reset_instr_out", 64'(instr_out), 64'(NOP_INSTR));
        @(posedge clk);
        #1 reset = 1'b0;

        // Streaming and stall, cycle by cycle
        for (int i = 0; i < 16; i++) begin
            stepCycle();
            stall = vecs[i].stall;
            checkOutput($sformatf("c%0d_req_valid", i), 64'(imem_req_valid), 64'(vecs[i].expReqValid));
            if (vecs[i].expReqValid)
                checkOutput($sformatf("c%0d_req_addr", i), imem_req_addr, vecs[i].expAddr);
            checkOutput($sformatf("c%0d_valid_out", i), 64'(valid_out), 64'(vecs[i].expValid));
            checkOutput($sformatf("c%0d_pc_out", i), pc_out, vecs[i].expPc);
            checkOutput($sformatf("c%0d_instr_out", i), 64'(instr_out),
                        vecs[i].expValid ? 64'(dataOf(vecs[i].expPc)) : 64'(NOP_INSTR));
        end

        // Redirect coinciding with the response in WAIT: word dropped, no DRAIN cycle
        stepCycle();
        checkOutput("rsp_redir_pre_valid", 64'(valid_out), 64'd1);
        checkOutput("rsp_redir_pre_pc", pc_out, BASE + 64'd20);
        applyStimulus(1'b0, 1'b1, BASE + 64'h300);
        stepCycle();
        checkOutput("rsp_redir_valid_out", 64'(valid_out), 64'd0);
        checkOutput("rsp_redir_req_valid", 64'(imem_req_valid), 64'd1);
        checkOutput("rsp_redir_req_addr", imem_req_addr, BASE + 64'h300);
        waitValid("rsp_redir_first", BASE + 64'h300);

        // Redirect while WAIT, stale word arrives two cycles later
        memLat = 3;
        useOverride = 1'b1;
        overrideData = 32'hDEADBEEF;
        n = 0;
        do begin
            stepCycle();
            n++;
        end while (!acceptedNow && n < 20);
        checkOutput("wait_redir_accept_seen", 64'(acceptedNow), 64'd1);
        useOverride = 1'b0;
        memLat = 1;
        stepCycle();
        checkOutput("wait_redir_in_wait", 64'(imem_req_valid), 64'd0);
        applyStimulus(1'b0, 1'b1, BASE + 64'h100);
        stepCycle();
        checkOutput("wait_redir_drain1_req", 64'(imem_req_valid), 64'd0);
        checkOutput("wait_redir_drain1_valid", 64'(valid_out), 64'd0);
        stepCycle();
        checkOutput("wait_redir_drain2_req", 64'(imem_req_valid), 64'd0);
        stepCycle();
        checkOutput("wait_redir_resume_req", 64'(imem_req_valid), 64'd1);
        checkOutput("wait_redir_resume_addr", imem_req_addr, BASE + 64'h100);
        waitValid("wait_redir_first", BASE + 64'h100);
        checkOutput("wait_redir_no_deadbeef", 64'(sawDeadbeef), 64'd0);

        // PC wrap at the top of the address space
        applyStimulus(1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFF8);
        n = 0;
        while ((reqQ.size() < 3 || pcQ.size() < 3) && n < 40) begin
            stepCycle();
            if (acceptedNow && reqQ.size() < 3) reqQ.push_back(acceptedAddr);
            if (valid_out && pcQ.size() < 3) pcQ.push_back(pc_out);
            n++;
        end
        if (reqQ.size() < 3 || pcQ.size() < 3) begin
            checks++;
            failures++;
            $display("[TB] FAIL wrap_timeout: got %0d reqs %0d outputs expected 3 each", reqQ.size(), pcQ.size());
        end else begin
            checkOutput("wrap_req0", reqQ[0], 64'hFFFF_FFFF_FFFF_FFF8);
            checkOutput("wrap_req1", reqQ[1], 64'hFFFF_FFFF_FFFF_FFFC);
            checkOutput("wrap_req2", reqQ[2], 64'd0);
            checkOutput("wrap_pc0", pcQ[0], 64'hFFFF_FFFF_FFFF_FFF8);
            checkOutput("wrap_pc1", pcQ[1], 64'hFFFF_FFFF_FFFF_FFFC);
            checkOutput("wrap_pc2", pcQ[2], 64'd0);
        end

`ifdef IFETCH_MISALIGN_TRAP_EN
        // Misaligned redirect halts fetch until the next redirect
        applyStimulus(1'b0, 1'b1, BASE + 64'h102);
        stepCycle();
        checkOutput("mis_flag", 64'(fetch_misaligned), 64'd1);
        checkOutput("mis_valid_out", 64'(valid_out), 64'd0);
        checkOutput("mis_pc_out", pc_out, BASE + 64'h102);
        checkOutput("mis_instr_out", 64'(instr_out), 64'(NOP_INSTR));
        n = 0;
        for (int i = 0; i < 6; i++) begin
            stepCycle();
            if (imem_req_valid) n++;
        end
        checkOutput("mis_no_requests", 64'(n), 64'd0);
        applyStimulus(1'b0, 1'b1, BASE + 64'h200);
        stepCycle();
        checkOutput("mis_resume_req", 64'(imem_req_valid), 64'd1);
        checkOutput("mis_resume_addr", imem_req_addr, BASE + 64'h200);
        waitValid("mis_resume_first", BASE + 64'h200);
`else
        // Low address bits of the redirect target are ignored
        applyStimulus(1'b0, 1'b1, BASE + 64'h402);
        n = 0;
        reqQ.delete();
        while (reqQ.size() < 1 && n < 20) begin
            stepCycle();
            if (acceptedNow) reqQ.push_back(acceptedAddr);
            n++;
        end
        if (reqQ.size() < 1) begin
            checks++;
            failures++;
            $display("[TB] FAIL align_timeout: got no request expected %h", BASE + 64'h400);
        end else begin
            checkOutput("align_req_addr", reqQ[0], BASE + 64'h400);
        end
        waitValid("align_first", BASE + 64'h400);
`endif

        repeat (3) stepCycle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
